// File: rtl/nx_arbiter_rr_pkg.sv
// Shared types and limits for the Nexus round-robin packet arbiter.
package nx_arbiter_rr_pkg;

    typedef enum logic [0:0] {
        NX_ARB_IDLE,
        NX_ARB_LOCKED
    } nx_arb_state_t;

    // Largest channel count the arbiter is qualified for.
    function automatic int unsigned nx_arb_max_inputs();
        return 32'd16;
    endfunction

endpackage

// File: rtl/nx_rr_picker.sv
// Combinational round-robin picker: first set request bit after 'pointer', wrapping.
module nx_rr_picker #(
    parameter int unsigned INPUTS = 4,
    parameter int unsigned IDX_W  = $clog2(INPUTS)
) (
    input  logic [INPUTS-1:0] request,
    input  logic [IDX_W-1:0]  pointer,
    output logic              found,
    output logic [IDX_W-1:0]  index
);

    // Two passes: channels above the pointer first, then wrap to those at or below it.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (!found && request[i] && (IDX_W'(i) > pointer)) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
        for (int i = 0; i < INPUTS; i++) begin
            if (!found && request[i] && (IDX_W'(i) <= pointer)) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/nx_arbiter_rr.sv
// N-input packet-atomic round-robin arbiter with registered, source-tagged output.
// Optional per-input packet counters: define NX_ARBITER_RR_STATS_EN.
module nx_arbiter_rr
    import nx_arbiter_rr_pkg::*;
#(
    parameter int unsigned BUS_W  = 8,
    parameter int unsigned INPUTS = 4,
    parameter int unsigned STAT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [INPUTS*BUS_W-1:0]     inbound_data,
    input  logic [INPUTS-1:0]           inbound_last,
    input  logic [INPUTS-1:0]           inbound_valid,
    output logic [INPUTS-1:0]           inbound_ready,
    output logic [BUS_W-1:0]            outbound_data,
    output logic                        outbound_last,
    output logic [$clog2(INPUTS)-1:0]   outbound_source,
    output logic                        outbound_valid,
    input  logic                        outbound_ready
`ifdef NX_ARBITER_RR_STATS_EN
    ,
    output logic [INPUTS*STAT_W-1:0]    stat_packets
`endif
);

    localparam int unsigned IDX_W = $clog2(INPUTS);

    if (INPUTS < 2 || INPUTS > nx_arb_max_inputs() || STAT_W == 0) begin : g_param_check
        $error("nx_arbiter_rr: illegal INPUTS or STAT_W");
    end

    nx_arb_state_t      state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [BUS_W-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [IDX_W-1:0]   out_src_q, out_src_d;
    logic               out_valid_q, out_valid_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_index;
    logic               slot_free;
    logic               grant_ok;
    logic [IDX_W-1:0]   sel;
    logic [BUS_W-1:0]   sel_data;
    logic               sel_last;
    logic               accept;

    nx_rr_picker #(
        .INPUTS (INPUTS),
        .IDX_W  (IDX_W)
    ) u_picker (
        .request (inbound_valid),
        .pointer (ptr_q),
        .found   (pick_found),
        .index   (pick_index)
    );

    assign slot_free = !out_valid_q || outbound_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= NX_ARB_IDLE;
            ptr_q       <= IDX_W'(INPUTS - 1);
            grant_q     <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Grant selection, ready generation and output-register update.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        out_src_d     = out_src_q;
        out_valid_d   = out_valid_q;
        inbound_ready = '0;
        sel           = grant_q;
        grant_ok      = 1'b0;
        sel_data      = '0;
        sel_last      = 1'b0;
        accept        = 1'b0;

        case (state_q)
            NX_ARB_IDLE: begin
                sel      = pick_index;
                grant_ok = pick_found;
            end
            NX_ARB_LOCKED: begin
                grant_ok = 1'b1;
            end
            default: ;
        endcase

        // Ready never looks at data or last, only at valid (via the picker) and slot state.
        for (int i = 0; i < INPUTS; i++) begin
            if (grant_ok && slot_free && !rst && (IDX_W'(i) == sel)) begin
                inbound_ready[i] = 1'b1;
            end
        end

        for (int i = 0; i < INPUTS; i++) begin
            if (IDX_W'(i) == sel) begin
                sel_data = inbound_data[i*BUS_W +: BUS_W];
                sel_last = inbound_last[i];
                accept   = inbound_ready[i] && inbound_valid[i];
            end
        end

        if (accept) begin
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = sel;
            out_valid_d = 1'b1;
            if (sel_last) begin
                state_d = NX_ARB_IDLE;
                ptr_d   = sel;
            end else begin
                state_d = NX_ARB_LOCKED;
                grant_d = sel;
            end
        end else if (outbound_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign outbound_data   = out_data_q;
    assign outbound_last   = out_last_q;
    assign outbound_source = out_src_q;
    assign outbound_valid  = out_valid_q;

`ifdef NX_ARBITER_RR_STATS_EN
    logic [STAT_W-1:0] stat_q [INPUTS];
    logic [STAT_W-1:0] stat_d [INPUTS];

    // Saturating count of completed packets per channel.
    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            stat_d[i] = stat_q[i];
            if (accept && sel_last && (IDX_W'(i) == sel) && (stat_q[i] != '1)) begin
                stat_d[i] = stat_q[i] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < INPUTS; i++) begin
            if (rst) begin
                stat_q[i] <= '0;
            end else begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    for (genvar g = 0; g < INPUTS; g++) begin : g_stat_out
        assign stat_packets[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule
